ps2_rx_fifo: RTL
================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of buffered scancode entries; SHALL be a power of two and at least 2.
REQ-002 Parameter FILTER_LEN, default 8, number of consecutive equal Clock samples required before the filtered PS2_CLK level changes.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, number of Clock cycles without a filtered falling edge that aborts a frame in progress.
REQ-004 Clock  input  1  system clock; all state SHALL change only on its rising edge, except on reset.
REQ-005 Reset  input  1  reset Reset, asynchronous, active-high; clock Clock.
REQ-006 PS2_CLK  input  1  raw keyboard clock, asynchronous to Clock, idle high.
REQ-007 PS2_DATA  input  1  raw keyboard data, asynchronous to Clock, idle high.
REQ-008 iPop  input  1  one-cycle strobe that removes the head entry.
REQ-009 oCode  output  8  head-entry scancode, valid while oValid=1.
REQ-010 oBreak  output  1  head entry was preceded by F0 (key release).
REQ-011 oExtended  output  1  head entry was preceded by E0.
REQ-012 oValid  output  1  FIFO not empty.
REQ-013 oFull  output  1  FIFO holds FIFO_DEPTH entries.
REQ-014 oCount  output  clog2(FIFO_DEPTH+1)  current occupancy.
REQ-015 oParityError  output  1  one-cycle pulse when a frame fails the odd-parity check.
REQ-016 oFrameError  output  1  one-cycle pulse on a bad stop bit or on timeout.
REQ-017 oOverflow  output  1  one-cycle pulse when an entry is dropped because the FIFO is full.

Function
REQ-018 PS2_CLK and PS2_DATA SHALL each pass through a 2-flop synchronizer before use.
- The filtered clock level SHALL toggle only after FILTER_LEN consecutive synchronized samples differ from the current filtered level.
- A falling-edge strobe SHALL be asserted for exactly one Clock cycle per filtered 1->0 transition.
REQ-019 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP, with all transitions taken on the falling-edge strobe and synchronized PS2_DATA sampled in the same cycle.
- IDLE: data=0 (start bit) -> DATA with the bit counter cleared; data=1 -> remain in IDLE.
- DATA: shift the bit in LSB first; after the 8th bit -> PARITY.
- PARITY: capture the bit -> STOP.
- STOP -> IDLE in all cases.
REQ-020 At STOP, the frame SHALL be checked in this order:
- Stop bit 0 -> pulse oFrameError, discard the byte.
- Otherwise, parity wrong (XOR of the 8 data bits plus the parity bit not equal to 1) -> pulse oParityError, discard the byte.
- Otherwise, the byte is accepted.
REQ-021 While the FSM is not in IDLE, a cycle counter SHALL count Clock cycles since the last falling-edge strobe.
- Reaching TIMEOUT_CYCLES -> return to IDLE, pulse oFrameError, discard the partial byte.
- The counter SHALL clear on every strobe and while in IDLE.
REQ-022 An accepted 0xE0 SHALL set the pending-extended flag and an accepted 0xF0 SHALL set the pending-break flag; neither byte is pushed to the FIFO.
REQ-023 Any other accepted byte SHALL be pushed as {extended, break, code}, and both pending flags SHALL clear in the same cycle.
REQ-024 Pending flags SHALL be unaffected by discarded or timed-out frames.
REQ-025 The push SHALL occur on the Clock edge ending the STOP-strobe cycle, and oValid/oCount SHALL reflect it in the next cycle (1-cycle latency from the stop-bit edge).
REQ-026 The FIFO SHALL be show-ahead: oCode, oBreak and oExtended continuously present the head entry, and are 0 when the FIFO is empty.
REQ-027 iPop while empty SHALL be ignored, with no underflow and no pointer change.
REQ-028 A push while full without a simultaneous pop SHALL drop the entry and pulse oOverflow; stored contents remain unchanged.
REQ-029 A simultaneous push and pop SHALL both take effect with oCount unchanged.
- This holds when full; no oOverflow is raised.
- When empty, only the push takes effect.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
- oFull SHALL equal (oCount==FIFO_DEPTH).
- oValid SHALL equal (oCount!=0).

Reset
REQ-031 On Reset=1, independent of Clock:
- FSM -> IDLE.
- Counters, pointers, pending flags and oCount -> 0.
- Synchronizer flops and the filtered clock level -> 1.
- All outputs -> 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame and all FIFO contents; the block SHALL resume at the next start bit after release.

Verification
REQ-033 Frame 0x1D with parity bit 1 and stop bit 1 -> one cycle after the stop edge: oValid=1, oCode=0x1D, oBreak=0, oExtended=0, oCount=1; iPop -> oValid=0.
REQ-034 Frames F0, 1D -> a single entry with oCode=0x1D, oBreak=1, oExtended=0; frames E0, F0, 75 -> a single entry with oCode=0x75, oBreak=1, oExtended=1.
REQ-035 Frame 0x1D with parity bit 0 -> one oParityError pulse, oCount stays 0; the next valid frame 0x1C is pushed normally.
REQ-036 Start bit plus 4 data bits, then PS2_CLK held high for TIMEOUT_CYCLES -> one oFrameError pulse, FSM back in IDLE; the following full frame 0x1D is received correctly.
REQ-037 FIFO_DEPTH=4, 5 valid frames with no pops -> oFull=1, oCount=4, one oOverflow pulse on the 5th; pops return the first 4 codes in order.
REQ-038 Glitch of FILTER_LEN-1 Clock cycles low on an idle PS2_CLK -> no strobe, FSM stays in IDLE; Reset mid-frame -> oCount=0, all outputs 0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   Receives PS/2 keyboard frames and queues scancodes in a show-ahead FIFO.
//   The raw PS2_CLK is synchronized and glitch-filtered, and its falling edges
//   drive the frame FSM. E0 and F0 prefix bytes are folded into flags on the
//   next code byte instead of being queued.
//
// Ports
//   Clock, Reset      system clock; asynchronous active-high reset
//   PS2_CLK, PS2_DATA raw keyboard lines (asynchronous, idle high)
//   iPop              removes the head entry (ignored when empty)
//   oCode/oBreak/oExtended  head entry, all 0 while empty
//   oValid, oFull, oCount   FIFO status
//   oParityError, oFrameError, oOverflow  one-cycle event pulses
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | waiting for a start bit (data 0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and parity, delivering the byte

module ps2_rx_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                            Clock,
   input  logic                            Reset,
   input  logic                            PS2_CLK,
   input  logic                            PS2_DATA,
   input  logic                            iPop,
   output logic [7:0]                      oCode,
   output logic                            oBreak,
   output logic                            oExtended,
   output logic                            oValid,
   output logic                            oFull,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] oCount,
   output logic                            oParityError,
   output logic                            oFrameError,
   output logic                            oOverflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          state, state_nx;
   logic            clk_s1, clk_s2, dat_s1, dat_s2;
   logic            clk_flt, fall_stb;
   logic [FW-1:0]   flt_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [7:0]      shift_reg;
   logic [2:0]      bit_cnt;
   logic            par_bit;
   logic            pend_ext, pend_brk;
   logic            frame_err, par_err, byte_ok;
   logic            push, do_push, do_pop, full;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [9:0]      mem [FIFO_DEPTH];
   logic [9:0]      head;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= PS2_CLK;
         clk_s2 <= clk_s1;
         dat_s1 <= PS2_DATA;
         dat_s2 <= dat_s1;
      end
   end

   // Down-counter reloads whenever the sample agrees with the filtered level,
   // so it only reaches zero after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         clk_flt  <= 1'b1;
         flt_cnt  <= '0;
         fall_stb <= 1'b0;
      end else begin
         fall_stb <= 1'b0;
         if (clk_s2 == clk_flt) begin
            flt_cnt <= FLT_LOAD;
         end else if (flt_cnt == '0) begin
            clk_flt  <= clk_s2;
            flt_cnt  <= FLT_LOAD;
            fall_stb <= clk_flt;
         end else begin
            flt_cnt <= flt_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      frame_err = 1'b0;
      par_err   = 1'b0;
      byte_ok   = 1'b0;
      if (state != S_IDLE && !fall_stb && tmo_cnt == '0) begin
         state_nx  = S_IDLE;
         frame_err = 1'b1;
      end else if (fall_stb) begin
         case (state)
            S_IDLE:   if (!dat_s2) state_nx = S_DATA;
            S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
            S_PARITY: state_nx = S_STOP;
            S_STOP: begin
               state_nx = S_IDLE;
               if (!dat_s2)                      frame_err = 1'b1;
               else if (!(^{shift_reg, par_bit})) par_err  = 1'b1;
               else                              byte_ok   = 1'b1;
            end
            default:  state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         par_bit   <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         if (fall_stb) begin
            case (state)
               S_IDLE: bit_cnt <= '0;
               S_DATA: begin
                  shift_reg <= {dat_s2, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end
               S_PARITY: par_bit <= dat_s2;
               default: ;
            endcase
         end
         if (state == S_IDLE || fall_stb) tmo_cnt <= TMO_LOAD;
         else if (tmo_cnt != '0)          tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign push    = byte_ok && shift_reg != 8'hE0 && shift_reg != 8'hF0;
   assign full    = (count == DEPTH_C);
   assign do_pop  = iPop && (count != '0);
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pend_ext     <= 1'b0;
         pend_brk     <= 1'b0;
         oParityError <= 1'b0;
         oFrameError  <= 1'b0;
         oOverflow    <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
      end else begin
         oParityError <= par_err;
         oFrameError  <= frame_err;
         oOverflow    <= push && full && !do_pop;
         if (byte_ok) begin
            if (shift_reg == 8'hE0) begin
               pend_ext <= 1'b1;
            end else if (shift_reg == 8'hF0) begin
               pend_brk <= 1'b1;
            end else begin
               pend_ext <= 1'b0;
               pend_brk <= 1'b0;
            end
         end
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (do_push) mem[wr_ptr] <= {pend_ext, pend_brk, shift_reg};
   end

   assign head      = mem[rd_ptr];
   assign oValid    = (count != '0);
   assign oFull     = full;
   assign oCount    = count;
   assign oCode     = oValid ? head[7:0] : 8'h00;
   assign oBreak    = oValid & head[8];
   assign oExtended = oValid & head[9];

endmodule
